// File: rtl/sensor_monitor_pkg.sv
// Shared types and constants for the irrigation sensor fault supervisor.
package sensor_monitor_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    ACTIVE  = 2'd1,
    LATCHED = 2'd2
  } state_t;

  localparam int unsigned SN          = 0;
  localparam int unsigned SR          = 1;
  localparam int unsigned SP          = 2;
  localparam int unsigned NUM_SENSORS = 3;

  localparam logic [NUM_SENSORS-1:0] SENSOR_RESET_LEVEL = 3'b111;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser plus consecutive-sample debounce filter for one switch.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Accept the new level only on the Nth consecutive differing sample.
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sensor_monitor.sv
// Sensor fault supervisor: debounced switches, latched fault FSM, sticky mask, blinking alarm.
module sensor_monitor
  import sensor_monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BLINK_HALF      = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] chaves_sensores,
  input  logic       ack,
  output logic [2:0] sensores_ok,
  output logic       erro,
  output logic       led_alarme,
  output logic [2:0] fault_mask
);

  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t        state;
  state_t        state_next;
  logic          any_low;
  logic          ack_sync1;
  logic          ack_sync2;
  logic          ack_prev;
  logic          ack_edge;
  logic [BW-1:0] blink_cnt;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_db
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (chaves_sensores[i]),
      .stable(sensores_ok[i])
    );
  end

  assign any_low = ~&sensores_ok;
  assign erro    = (state != OK);

  // The acknowledge edge is registered so the FSM acts on it one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_sync1 <= 1'b0;
      ack_sync2 <= 1'b0;
      ack_prev  <= 1'b0;
      ack_edge  <= 1'b0;
    end else begin
      ack_sync1 <= ack;
      ack_sync2 <= ack_sync1;
      ack_prev  <= ack_sync2;
      ack_edge  <= ack_sync2 & ~ack_prev;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      OK:      if (any_low) state_next = ACTIVE;
      ACTIVE:  if (!any_low) state_next = LATCHED;
      LATCHED: begin
        if (any_low)       state_next = ACTIVE;
        else if (ack_edge) state_next = OK;
      end
      default: state_next = OK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OK;
      fault_mask <= '0;
      led_alarme <= 1'b0;
      blink_cnt  <= '0;
    end else begin
      state <= state_next;

      if (state_next == OK) fault_mask <= '0;
      else                  fault_mask <= fault_mask | ~sensores_ok;

      unique case (state_next)
        OK: begin
          led_alarme <= 1'b0;
          blink_cnt  <= '0;
        end
        ACTIVE: begin
          led_alarme <= 1'b1;
          blink_cnt  <= '0;
        end
        LATCHED: begin
          // Blink phase restarts lit on every fresh entry to LATCHED.
          if (state != LATCHED) begin
            led_alarme <= 1'b1;
            blink_cnt  <= '0;
          end else if (blink_cnt == BLINK_LAST) begin
            led_alarme <= ~led_alarme;
            blink_cnt  <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: begin
          led_alarme <= 1'b0;
          blink_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_monitor.sv
// Self-checking bench for sensor_monitor: directed vector table plus randomized run against a reference model.
module tb_sensor_monitor;

  localparam int unsigned D  = 4;
  localparam int unsigned BH = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic       ack;
  logic [2:0] sensores_ok;
  logic       erro;
  logic       led_alarme;
  logic [2:0] fault_mask;

  always #5 clk = ~clk;

  sensor_monitor #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_HALF     (BH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chaves_sensores(sw),
    .ack            (ack),
    .sensores_ok    (sensores_ok),
    .erro           (erro),
    .led_alarme     (led_alarme),
    .fault_mask     (fault_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw input history per edge, newest at index 0.
  logic [2:0] h_sw  [0:15];
  logic       h_ack [0:15];
  logic [2:0] m_ok   = 3'b111;
  logic [2:0] m_mask = 3'b000;
  logic       m_led  = 1'b0;
  int         m_state = 0;  // 0 = no fault, 1 = fault present, 2 = fault remembered
  int         m_t     = 0;  // edges since entering the remembered state

  typedef struct {
    int         cycles;
    logic       rst_n;
    logic [2:0] sw;
    logic       ack;
    logic [2:0] e_ok;
    logic       e_erro;
    logic       e_led;
    logic [2:0] e_mask;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at time %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] old_ok;
    logic       any_low;
    logic       ack_act;
    logic       all_diff;
    int         nxt;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        h_sw[i]  = 3'b111;
        h_ack[i] = 1'b0;
      end
      m_ok = 3'b111; m_mask = 3'b000; m_led = 1'b0; m_state = 0; m_t = 0;
    end else begin
      for (int i = 15; i > 0; i--) begin
        h_sw[i]  = h_sw[i-1];
        h_ack[i] = h_ack[i-1];
      end
      h_sw[0]  = sw;
      h_ack[0] = ack;
      old_ok  = m_ok;
      any_low = (old_ok != 3'b111);
      // Press sampled 3 edges ago, released 4 edges ago.
      ack_act = h_ack[3] && !h_ack[4];
      nxt = m_state;
      if (m_state == 0)      nxt = any_low ? 1 : 0;
      else if (m_state == 1) nxt = any_low ? 1 : 2;
      else                   nxt = any_low ? 1 : (ack_act ? 0 : 2);
      m_mask = (nxt == 0) ? 3'b000 : (m_mask | ~old_ok);
      if (nxt == 2) m_t = (m_state != 2) ? 0 : m_t + 1;
      else          m_t = 0;
      if (nxt == 0)      m_led = 1'b0;
      else if (nxt == 1) m_led = 1'b1;
      else               m_led = ((m_t / BH) % 2) == 0;
      m_state = nxt;
      // A sensor level flips once its synced value has disagreed for D consecutive edges.
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int j = 2; j < D + 2; j++)
          if (h_sw[j][b] == old_ok[b]) all_diff = 1'b0;
        if (all_diff) m_ok[b] = ~old_ok[b];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_sensores_ok", sensores_ok, m_ok);
    check("model_erro", {2'b00, erro}, {2'b00, m_state != 0});
    check("model_led_alarme", {2'b00, led_alarme}, {2'b00, m_led});
    check("model_fault_mask", fault_mask, m_mask);
  endtask

  task automatic add(input int c, input logic r, input logic [2:0] s, input logic a,
                     input logic [2:0] eo, input logic ee, input logic el, input logic [2:0] em);
    vec_t v;
    v.cycles = c; v.rst_n = r; v.sw = s; v.ack = a;
    v.e_ok = eo; v.e_erro = ee; v.e_led = el; v.e_mask = em;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 3'b111;
    ack   = 1'b0;

    //  cyc rst  sw      ack    ok      erro  led   mask
    add( 2, 0, 3'b111, 0, 3'b111, 0, 0, 3'b000);  // reset
    add(20, 1, 3'b111, 0, 3'b111, 0, 0, 3'b000);  // idle hold
    add( 3, 1, 3'b101, 0, 3'b111, 0, 0, 3'b000);  // SR glitch
    add( 8, 1, 3'b111, 0, 3'b111, 0, 0, 3'b000);
    add( 5, 1, 3'b101, 0, 3'b111, 0, 0, 3'b000);  // SR held low
    add( 1, 1, 3'b101, 0, 3'b101, 0, 0, 3'b000);  // debounced after edge D+1
    add( 1, 1, 3'b101, 0, 3'b101, 1, 1, 3'b010);  // fault one edge later
    add( 6, 1, 3'b101, 1, 3'b101, 1, 1, 3'b010);  // ack ignored while active
    add( 4, 1, 3'b101, 0, 3'b101, 1, 1, 3'b010);
    add( 6, 1, 3'b111, 0, 3'b111, 1, 1, 3'b010);  // SR restored
    add( 1, 1, 3'b111, 0, 3'b111, 1, 1, 3'b010);  // latched entry
    add( 2, 1, 3'b111, 0, 3'b111, 1, 1, 3'b010);
    add( 1, 1, 3'b111, 0, 3'b111, 1, 0, 3'b010);  // blink off
    add( 2, 1, 3'b111, 0, 3'b111, 1, 0, 3'b010);
    add( 1, 1, 3'b111, 0, 3'b111, 1, 1, 3'b010);  // blink on
    add( 3, 1, 3'b111, 1, 3'b111, 1, 0, 3'b010);  // ack pressed, not yet acted on
    add( 1, 1, 3'b111, 1, 3'b111, 0, 0, 3'b000);  // back to OK third edge later
    add( 6, 1, 3'b111, 1, 3'b111, 0, 0, 3'b000);  // held ack: single transition
    add( 3, 1, 3'b111, 0, 3'b111, 0, 0, 3'b000);
    add( 7, 1, 3'b101, 0, 3'b101, 1, 1, 3'b010);  // re-enter active
    add( 7, 1, 3'b111, 0, 3'b111, 1, 1, 3'b010);  // latched, t=0
    add( 3, 1, 3'b011, 0, 3'b111, 1, 0, 3'b010);  // SP drops
    add( 3, 1, 3'b011, 1, 3'b011, 1, 1, 3'b010);  // ack timed to coincide
    add( 1, 1, 3'b011, 1, 3'b011, 1, 1, 3'b110);  // fault wins over ack
    add( 4, 1, 3'b011, 1, 3'b011, 1, 1, 3'b110);
    add( 4, 1, 3'b011, 0, 3'b011, 1, 1, 3'b110);
    add( 7, 1, 3'b111, 0, 3'b111, 1, 1, 3'b110);  // latched again
    add( 2, 1, 3'b110, 0, 3'b111, 1, 1, 3'b110);  // SN low in latched
    add( 1, 0, 3'b110, 0, 3'b111, 0, 0, 3'b000);  // one-edge reset
    add( 6, 1, 3'b110, 0, 3'b110, 0, 0, 3'b000);
    add( 2, 1, 3'b110, 0, 3'b110, 1, 1, 3'b001);  // active again
    add( 8, 1, 3'b111, 0, 3'b111, 1, 1, 3'b001);

    foreach (vecs[k]) begin
      rst_n = vecs[k].rst_n;
      sw    = vecs[k].sw;
      ack   = vecs[k].ack;
      for (int c = 0; c < vecs[k].cycles; c++) tick();
      check($sformatf("vec%0d_sensores_ok", k), sensores_ok, vecs[k].e_ok);
      check($sformatf("vec%0d_erro", k), {2'b00, erro}, {2'b00, vecs[k].e_erro});
      check($sformatf("vec%0d_led_alarme", k), {2'b00, led_alarme}, {2'b00, vecs[k].e_led});
      check($sformatf("vec%0d_fault_mask", k), fault_mask, vecs[k].e_mask);
    end

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0)
        sw = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) ack = ~ack;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
